// File: rtl/spi_slave_fl_pkg.sv
// Shared definitions for the flash-style SPI responder: field widths,
// command-type encoding (common with the flash SPI master) and FSM state codes.
package spi_slave_fl_pkg;

  localparam int SPI_DATA_W = 32;
  localparam int SPI_ADDR_W = 24;
  localparam int SPI_COM_W  = 8;
  localparam int SPI_CTYP_W = 3;

  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD           = 3'b000;
  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD_ANS       = 3'b001;
  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD_ADDR_ANS  = 3'b010;
  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD_DATA      = 3'b011;
  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD_ADDR_DATA = 3'b100;
  localparam logic [SPI_CTYP_W-1:0] CTYP_CMD_ADDR      = 3'b101;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_ADDR     = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_ANS      = 3'd4;
  localparam logic [2:0] ST_WAIT_END = 3'd5;

  // Reserved encodings 110/111 behave as a bare command.
  function automatic logic [SPI_CTYP_W-1:0] ctyp_norm(input logic [SPI_CTYP_W-1:0] i_t);
    case (i_t)
      CTYP_CMD_ANS, CTYP_CMD_ADDR_ANS, CTYP_CMD_DATA,
      CTYP_CMD_ADDR_DATA, CTYP_CMD_ADDR: ctyp_norm = i_t;
      default:                           ctyp_norm = CTYP_CMD;
    endcase
  endfunction

endpackage

// File: rtl/spi_slave_fl_sync_edge.sv
// Multi-flop synchronizer with one history flop producing rise/fall pulses
// (module spi_sync_edge). SYNC_STAGES must be 2 or 3.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_hist <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_q    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_q & ~r_hist;
  assign o_fall = ~o_q & r_hist;

endmodule

// File: rtl/spi_slave_fl.sv
// SPI flash-style responder (mode 0), oversampled in i_clk. Optional macro
// SPI_SLAVE_FL_ERRCNT_EN adds a saturating aborted-frame counter o_err_count.
//
// state    | meaning
// IDLE     | waiting for ss fall
// CMD      | shifting in command byte; one extra cycle to decode cmd_type
// ADDR     | shifting in address
// DATA     | shifting in write data
// ANS      | driving answer word on miso at sclk falls
// WAIT_END | frame body complete, waiting for ss rise
module spi_slave_fl
  import spi_slave_fl_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int ADDR_W      = SPI_ADDR_W,
  parameter int COM_W       = SPI_COM_W,
  parameter int CTYP_W      = SPI_CTYP_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sclk,
  input  logic              i_ss,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [COM_W-1:0]  o_cmd_out,
  output logic              o_cmd_valid,
  input  logic [CTYP_W-1:0] i_cmd_type,
  output logic [ADDR_W-1:0] o_addr_out,
  output logic [DATA_W-1:0] o_data_out,
  input  logic [DATA_W-1:0] i_ans_data,
  output logic              o_frame_valid,
  output logic              o_frame_err
`ifdef SPI_SLAVE_FL_ERRCNT_EN
  ,
  output logic [7:0]        o_err_count
`endif
);

  localparam int MAX_W = (DATA_W > ADDR_W) ? ((DATA_W > COM_W) ? DATA_W : COM_W)
                                           : ((ADDR_W > COM_W) ? ADDR_W : COM_W);
  localparam int CNT_W = $clog2(MAX_W);

  logic w_sclk_q_unused, w_sclk_rise, w_sclk_fall;
  logic w_ss_q, w_ss_rise, w_ss_fall;
  logic w_mosi_q, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_rise, w_fall;
  logic [SPI_CTYP_W-1:0] w_ctyp;

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_bitcnt;
  logic [SPI_CTYP_W-1:0] r_ctyp;
  logic [DATA_W-1:0]     r_ans_sh;
  logic                  r_miso;
  logic [COM_W-1:0]      r_cmd;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_data;
  logic                  r_cmd_valid;
  logic                  r_frame_valid;
  logic                  r_frame_err;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_sclk),
    .o_q(w_sclk_q_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  // ss resets high so a released reset never looks like a frame start.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_ss),
    .o_q(w_ss_q), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_mosi),
    .o_q(w_mosi_q), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  assign w_rise = w_sclk_rise & ~w_ss_q;
  assign w_fall = w_sclk_fall & ~w_ss_q;
  assign w_ctyp = ctyp_norm(SPI_CTYP_W'(i_cmd_type));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_bitcnt      <= '0;
      r_ctyp        <= CTYP_CMD;
      r_ans_sh      <= '0;
      r_miso        <= 1'b1;
      r_cmd         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_cmd_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_cmd_valid   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      if (r_state != ST_IDLE && w_ss_rise) begin
        if (r_state == ST_WAIT_END) r_frame_valid <= 1'b1;
        else                        r_frame_err   <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_ss_fall) begin
              r_state  <= ST_CMD;
              r_bitcnt <= CNT_W'(COM_W-1);
            end
          end
          ST_CMD: begin
            // cmd_valid cycle: backend has decoded cmd_out into cmd_type
            if (r_cmd_valid) begin
              r_ctyp <= w_ctyp;
              case (w_ctyp)
                CTYP_CMD_ANS: begin
                  r_state  <= ST_ANS;
                  r_ans_sh <= i_ans_data;
                  r_bitcnt <= CNT_W'(DATA_W-1);
                end
                CTYP_CMD_DATA: begin
                  r_state  <= ST_DATA;
                  r_bitcnt <= CNT_W'(DATA_W-1);
                end
                CTYP_CMD_ADDR_ANS, CTYP_CMD_ADDR_DATA, CTYP_CMD_ADDR: begin
                  r_state  <= ST_ADDR;
                  r_bitcnt <= CNT_W'(ADDR_W-1);
                end
                default: r_state <= ST_WAIT_END;
              endcase
            end else if (w_rise) begin
              r_cmd <= {r_cmd[COM_W-2:0], w_mosi_q};
              if (r_bitcnt == '0) r_cmd_valid <= 1'b1;
              else                r_bitcnt    <= r_bitcnt - 1'b1;
            end
          end
          ST_ADDR: begin
            if (w_rise) begin
              r_addr <= {r_addr[ADDR_W-2:0], w_mosi_q};
              if (r_bitcnt == '0) begin
                case (r_ctyp)
                  CTYP_CMD_ADDR_ANS: begin
                    r_state  <= ST_ANS;
                    r_ans_sh <= i_ans_data;
                    r_bitcnt <= CNT_W'(DATA_W-1);
                  end
                  CTYP_CMD_ADDR_DATA: begin
                    r_state  <= ST_DATA;
                    r_bitcnt <= CNT_W'(DATA_W-1);
                  end
                  default: r_state <= ST_WAIT_END;
                endcase
              end else begin
                r_bitcnt <= r_bitcnt - 1'b1;
              end
            end
          end
          ST_DATA: begin
            if (w_rise) begin
              r_data <= {r_data[DATA_W-2:0], w_mosi_q};
              if (r_bitcnt == '0) r_state  <= ST_WAIT_END;
              else                r_bitcnt <= r_bitcnt - 1'b1;
            end
          end
          ST_ANS: begin
            if (w_fall) begin
              r_miso   <= r_ans_sh[DATA_W-1];
              r_ans_sh <= {r_ans_sh[DATA_W-2:0], 1'b0};
              if (r_bitcnt == '0) r_state  <= ST_WAIT_END;
              else                r_bitcnt <= r_bitcnt - 1'b1;
            end
          end
          ST_WAIT_END: r_state <= ST_WAIT_END;
          default:     r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_miso        = r_miso;
  assign o_miso_oe     = (r_state == ST_ANS);
  assign o_cmd_out     = r_cmd;
  assign o_cmd_valid   = r_cmd_valid;
  assign o_addr_out    = r_addr;
  assign o_data_out    = r_data;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_err   = r_frame_err;

`ifdef SPI_SLAVE_FL_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                   r_err_count <= '0;
    else if (r_frame_err && r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_spi_slave_fl.sv
// Directed self-checking bench for spi_slave_fl acting as a mode-0 SPI master
// with a small backend command decoder.
module tb_spi_slave_fl;

  localparam int H = 5;

  logic        clk;
  logic        rst;
  logic        sclk;
  logic        ss;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic [7:0]  cmd_out;
  logic        cmd_valid;
  logic [2:0]  cmd_type;
  logic [23:0] addr_out;
  logic [31:0] data_out;
  logic [31:0] ans_data;
  logic        frame_valid;
  logic        frame_err;
`ifdef SPI_SLAVE_FL_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cv   = 0;
  int n_fv   = 0;
  int n_fe   = 0;
  int n_oe   = 0;
  logic [7:0] cv_cmd = 8'h00;

  spi_slave_fl dut (
    .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_ss(ss), .i_mosi(mosi),
    .o_miso(miso), .o_miso_oe(miso_oe), .o_cmd_out(cmd_out), .o_cmd_valid(cmd_valid),
    .i_cmd_type(cmd_type), .o_addr_out(addr_out), .o_data_out(data_out),
    .i_ans_data(ans_data), .o_frame_valid(frame_valid), .o_frame_err(frame_err)
`ifdef SPI_SLAVE_FL_ERRCNT_EN
    , .o_err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (cmd_out)
      8'h06:   cmd_type = 3'b000;
      8'h9F:   cmd_type = 3'b001;
      8'h03:   cmd_type = 3'b010;
      8'h42:   cmd_type = 3'b011;
      8'h02:   cmd_type = 3'b100;
      8'h20:   cmd_type = 3'b101;
      default: cmd_type = 3'b111;
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid) begin
        n_cv++;
        cv_cmd = cmd_out;
      end
      if (frame_valid) n_fv++;
      if (frame_err) n_fe++;
      if (miso_oe) n_oe++;
    end
  end

  task automatic xfer(input logic [63:0] tx, input int ntx, input int nrx, input int rst_at,
                      output logic [31:0] rx, output int oe_bad,
                      output logic rst_miso, output logic rst_oe);
    rx = '0; oe_bad = 0; rst_miso = 1'b0; rst_oe = 1'b1;
    ss = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < ntx + nrx; i++) begin
      if (i < ntx) mosi = tx[ntx-1-i];
      repeat (H) @(negedge clk);
      if (rst_at >= 0 && i == ntx + rst_at) begin
        rst = 1'b0;
        #1;
        rst_miso = miso;
        rst_oe   = miso_oe;
        repeat (3) @(negedge clk);
        ss = 1'b1; sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (H) @(negedge clk);
        return;
      end
      if (i >= ntx) rx = {rx[30:0], miso};
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      if (nrx > 0 && i >= ntx - 1) begin
        if (i < ntx + nrx - 1) begin
          if (miso_oe !== 1'b1) oe_bad++;
        end else if (miso_oe !== 1'b0) oe_bad++;
      end
      sclk = 1'b0;
    end
    repeat (H) @(negedge clk);
    ss = 1'b1;
    repeat (2*H) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; ans_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (miso !== 1'b1) begin n_fail++; $display("FAIL rst_miso got %b want 1", miso); end
    n_cmp++; if (miso_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", miso_oe); end
    n_cmp++; if (cmd_out !== 8'h00) begin n_fail++; $display("FAIL rst_cmd got %h want 00", cmd_out); end
    n_cmp++; if (addr_out !== 24'h0) begin n_fail++; $display("FAIL rst_addr got %h want 0", addr_out); end
    n_cmp++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h want 0", data_out); end
    n_cmp++; if ({cmd_valid, frame_valid, frame_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_pulses got %b want 000", {cmd_valid, frame_valid, frame_err}); end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_cmd_only(input string nm);
    logic [31:0] rx; int ob; logic rm, ro;
    int cv0, fv0, fe0, oe0;
    cv0 = n_cv; fv0 = n_fv; fe0 = n_fe; oe0 = n_oe;
    xfer({56'h0, 8'h06}, 8, 0, -1, rx, ob, rm, ro);
    n_cmp++; if (n_cv - cv0 !== 1) begin n_fail++; $display("FAIL %s_cv_count got %0d want 1", nm, n_cv - cv0); end
    n_cmp++; if (cv_cmd !== 8'h06) begin n_fail++; $display("FAIL %s_cmd got %h want 06", nm, cv_cmd); end
    n_cmp++; if (n_fv - fv0 !== 1) begin n_fail++; $display("FAIL %s_fv got %0d want 1", nm, n_fv - fv0); end
    n_cmp++; if (n_fe - fe0 !== 0) begin n_fail++; $display("FAIL %s_fe got %0d want 0", nm, n_fe - fe0); end
    n_cmp++; if (n_oe - oe0 !== 0) begin n_fail++; $display("FAIL %s_oe_cycles got %0d want 0", nm, n_oe - oe0); end
  endtask

  task automatic test_cmd_ans(input logic [31:0] ans, input string nm);
    logic [31:0] rx; int ob; logic rm, ro;
    int fv0, fe0;
    fv0 = n_fv; fe0 = n_fe;
    ans_data = ans;
    xfer({56'h0, 8'h9F}, 8, 32, -1, rx, ob, rm, ro);
    n_cmp++; if (rx !== ans) begin n_fail++; $display("FAIL %s_rx got %h want %h", nm, rx, ans); end
    n_cmp++; if (ob !== 0) begin n_fail++; $display("FAIL %s_oe_window got %0d bad want 0", nm, ob); end
    n_cmp++; if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0) begin
      n_fail++; $display("FAIL %s_frame got fv=%0d fe=%0d want 1/0", nm, n_fv - fv0, n_fe - fe0); end
  endtask

  task automatic test_addr_ans();
    logic [31:0] rx; int ob; logic rm, ro;
    int fv0;
    fv0 = n_fv;
    ans_data = 32'hDEADBEEF;
    xfer({32'h0, 8'h03, 24'h123456}, 32, 32, -1, rx, ob, rm, ro);
    n_cmp++; if (addr_out !== 24'h123456) begin n_fail++; $display("FAIL t010_addr got %h want 123456", addr_out); end
    n_cmp++; if (rx !== 32'hDEADBEEF) begin n_fail++; $display("FAIL t010_rx got %h want deadbeef", rx); end
    n_cmp++; if (ob !== 0) begin n_fail++; $display("FAIL t010_oe_window got %0d bad want 0", ob); end
    n_cmp++; if (n_fv - fv0 !== 1) begin n_fail++; $display("FAIL t010_fv got %0d want 1", n_fv - fv0); end
  endtask

  task automatic test_addr_data();
    logic [31:0] rx; int ob; logic rm, ro;
    int fv0, fe0;
    fv0 = n_fv; fe0 = n_fe;
    xfer({8'h02, 24'h000100, 32'hA5A5F00F}, 64, 0, -1, rx, ob, rm, ro);
    n_cmp++; if (addr_out !== 24'h000100) begin n_fail++; $display("FAIL t100_addr got %h want 000100", addr_out); end
    n_cmp++; if (data_out !== 32'hA5A5F00F) begin n_fail++; $display("FAIL t100_data got %h want a5a5f00f", data_out); end
    n_cmp++; if (n_fv - fv0 !== 1 || n_fe - fe0 !== 0) begin
      n_fail++; $display("FAIL t100_frame got fv=%0d fe=%0d want 1/0", n_fv - fv0, n_fe - fe0); end
  endtask

  task automatic test_abort();
    logic [31:0] rx; int ob; logic rm, ro;
    int fv0, fe0;
    fv0 = n_fv; fe0 = n_fe;
    xfer({12'h0, 8'h02, 24'h0000AA, 20'h12345}, 52, 0, -1, rx, ob, rm, ro);
    n_cmp++; if (n_fe - fe0 !== 1 || n_fv - fv0 !== 0) begin
      n_fail++; $display("FAIL abort_frame got fe=%0d fv=%0d want 1/0", n_fe - fe0, n_fv - fv0); end
    n_cmp++; if (addr_out !== 24'h0000AA) begin n_fail++; $display("FAIL abort_addr got %h want 0000aa", addr_out); end
    n_cmp++; if (data_out !== 32'h00F12345) begin n_fail++; $display("FAIL abort_data got %h want 00f12345", data_out); end
`ifdef SPI_SLAVE_FL_ERRCNT_EN
    n_cmp++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL abort_errcnt got %0d want 1", err_count); end
`endif
    test_cmd_only("after_abort");
  endtask

  task automatic test_cmd_data_and_addr_only();
    logic [31:0] rx; int ob; logic rm, ro;
    int fv0;
    fv0 = n_fv;
    xfer({24'h0, 8'h42, 32'hCAFEF00D}, 40, 0, -1, rx, ob, rm, ro);
    n_cmp++; if (data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t011_data got %h want cafef00d", data_out); end
    xfer({32'h0, 8'h20, 24'h0ABCDE}, 32, 0, -1, rx, ob, rm, ro);
    n_cmp++; if (addr_out !== 24'h0ABCDE) begin n_fail++; $display("FAIL t101_addr got %h want 0abcde", addr_out); end
    n_cmp++; if (data_out !== 32'hCAFEF00D) begin n_fail++; $display("FAIL t101_data got %h want cafef00d", data_out); end
    n_cmp++; if (n_fv - fv0 !== 2) begin n_fail++; $display("FAIL t011_t101_fv got %0d want 2", n_fv - fv0); end
  endtask

  task automatic test_reset_mid_ans();
    logic [31:0] rx; int ob; logic rm, ro;
    ans_data = 32'h0F0F0F0F;
    xfer({56'h0, 8'h9F}, 8, 32, 10, rx, ob, rm, ro);
    n_cmp++; if (rm !== 1'b1) begin n_fail++; $display("FAIL midrst_miso got %b want 1", rm); end
    n_cmp++; if (ro !== 1'b0) begin n_fail++; $display("FAIL midrst_oe got %b want 0", ro); end
    n_cmp++; if (cmd_out !== 8'h00) begin n_fail++; $display("FAIL midrst_cmd got %h want 00", cmd_out); end
`ifdef SPI_SLAVE_FL_ERRCNT_EN
    n_cmp++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL midrst_errcnt got %0d want 0", err_count); end
`endif
    test_cmd_ans(32'h0F0F0F0F, "after_rst");
  endtask

  initial begin
    test_reset();
    test_cmd_only("t000");
    test_cmd_ans(32'hC2201600, "t001");
    test_addr_ans();
    test_addr_data();
    test_abort();
    test_cmd_data_and_addr_only();
    test_reset_mid_ans();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
